// File: rtl/game_graph_if.sv
// game_graph_if: player controls into the pong engine and VGA sync/colour out of it.
interface game_graph_if;
    logic [1:0] btn;
    logic [1:0] sw;
    logic       str;
    logic       hsync;
    logic       vsync;
    logic [2:0] rgb;

    modport master (output btn, sw, str, input hsync, vsync, rgb);
    modport slave  (input btn, sw, str, output hsync, vsync, rgb);
endinterface

// File: rtl/game_graph.sv
// game_graph: single-player pong engine for 640x480@60 VGA (pixel divider, sync, renderer, game state).
// Optional macro ROUND_BALL_EN draws the ball through an 8x8 round mask instead of a full square.
module game_graph #(
    parameter int unsigned H_DISP = 640,
    parameter int unsigned V_DISP = 480,
    parameter int unsigned BAR_V  = 4,
    parameter int unsigned BAR_H  = 72
) (
    input  logic        clk,
    input  logic        reset,
    game_graph_if.slave bus
);

    localparam int unsigned CW     = 10;
    localparam int unsigned H_FP   = 16;
    localparam int unsigned H_SYNC = 96;
    localparam int unsigned H_BP   = 48;
    localparam int unsigned V_FP   = 10;
    localparam int unsigned V_SYNC = 2;
    localparam int unsigned V_BP   = 33;

    localparam logic [CW-1:0] H_MAX   = CW'(H_DISP + H_FP + H_SYNC + H_BP - 1);
    localparam logic [CW-1:0] V_MAX   = CW'(V_DISP + V_FP + V_SYNC + V_BP - 1);
    localparam logic [CW-1:0] HS_BEG  = CW'(H_DISP + H_FP);
    localparam logic [CW-1:0] HS_END  = CW'(H_DISP + H_FP + H_SYNC - 1);
    localparam logic [CW-1:0] VS_BEG  = CW'(V_DISP + V_FP);
    localparam logic [CW-1:0] VS_END  = CW'(V_DISP + V_FP + V_SYNC - 1);
    localparam logic [CW-1:0] H_VIS   = CW'(H_DISP);
    localparam logic [CW-1:0] V_VIS   = CW'(V_DISP);
    localparam logic [CW-1:0] FRAME_V = CW'(V_DISP + 1);

    localparam logic [CW-1:0] WALL_L       = CW'(32);
    localparam logic [CW-1:0] WALL_R       = CW'(35);
    localparam logic [CW-1:0] BAR_L        = CW'(600);
    localparam logic [CW-1:0] BAR_R        = CW'(603);
    localparam logic [CW-1:0] BAR_STEP     = CW'(BAR_V);
    localparam logic [CW-1:0] BAR_SPAN     = CW'(BAR_H - 1);
    localparam logic [CW-1:0] BAR_UP_MIN   = CW'(3);
    localparam logic [CW-1:0] BAR_DN_LIM   = CW'(476);
    localparam logic [CW-1:0] BALL_SPAN    = CW'(7);
    localparam logic [CW-1:0] BALL_TOP_LIM = CW'(1);
    localparam logic [CW-1:0] BALL_BOT_LIM = CW'(478);
    localparam logic [CW-1:0] MISS_X       = CW'(636);
    localparam logic [CW-1:0] BAR_TOP_RST  = CW'(204);
    localparam logic [CW-1:0] BALL_X_RST   = CW'(300);
    localparam logic [CW-1:0] BALL_Y_RST   = CW'(240);

    logic          r_tick;
    logic [CW-1:0] r_h;
    logic [CW-1:0] r_v;
    logic          r_hsync;
    logic          r_vsync;
    logic [2:0]    r_rgb;
    logic [CW-1:0] r_bar_top;
    logic [CW-1:0] r_ball_x;
    logic [CW-1:0] r_ball_y;
    logic          r_dx;
    logic          r_dy;

    logic          w_tick;
    logic          w_frame_tick;
    logic          w_hsync;
    logic          w_vsync;
    logic          w_video_on;
    logic          w_wall;
    logic          w_bar;
    logic          w_ball_box;
    logic          w_ball_on;
    logic [2:0]    w_rgb;
    logic [CW-1:0] w_bar_next;
    logic [CW-1:0] w_vel;
    logic          w_hit_bar;
    logic          w_miss;
    logic          w_dx_next;
    logic          w_dy_next;
    logic [CW-1:0] w_x_next;
    logic [CW-1:0] w_y_next;

    // Pixel tick: every second clk edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_tick <= 1'b0;
        else       r_tick <= ~r_tick;
    end

    assign w_tick       = r_tick;
    assign w_frame_tick = w_tick && (r_h == '0) && (r_v == FRAME_V);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_h <= '0;
            r_v <= '0;
        end else if (w_tick) begin
            if (r_h == H_MAX) begin
                r_h <= '0;
                r_v <= (r_v == V_MAX) ? '0 : r_v + CW'(1);
            end else begin
                r_h <= r_h + CW'(1);
            end
        end
    end

    assign w_hsync    = !((r_h >= HS_BEG) && (r_h <= HS_END));
    assign w_vsync    = !((r_v >= VS_BEG) && (r_v <= VS_END));
    assign w_video_on = (r_h < H_VIS) && (r_v < V_VIS);
    assign w_wall     = (r_h >= WALL_L) && (r_h <= WALL_R);
    assign w_bar      = (r_h >= BAR_L) && (r_h <= BAR_R) &&
                        (r_v >= r_bar_top) && (r_v <= r_bar_top + BAR_SPAN);
    assign w_ball_box = (r_h >= r_ball_x) && (r_h <= r_ball_x + BALL_SPAN) &&
                        (r_v >= r_ball_y) && (r_v <= r_ball_y + BALL_SPAN);

`ifdef ROUND_BALL_EN
    function automatic logic [7:0] ball_mask_row(input logic [2:0] row);
        case (row)
            3'd0, 3'd7: ball_mask_row = 8'h3C;
            3'd1, 3'd6: ball_mask_row = 8'h7E;
            default:    ball_mask_row = 8'hFF;
        endcase
    endfunction

    logic [2:0] w_ball_row;
    logic [2:0] w_ball_col;
    logic [7:0] w_ball_mask;

    // Offsets inside the 8x8 box only need the low three bits; MSB of a row is the leftmost pixel.
    assign w_ball_row  = r_v[2:0] - r_ball_y[2:0];
    assign w_ball_col  = r_h[2:0] - r_ball_x[2:0];
    assign w_ball_mask = ball_mask_row(w_ball_row);
    assign w_ball_on   = w_ball_box && w_ball_mask[3'd7 - w_ball_col];
`else
    assign w_ball_on = w_ball_box;
`endif

    always_comb begin
        w_rgb = 3'b000;
        if (w_video_on) begin
            if (w_wall)         w_rgb = 3'b001;
            else if (w_bar)     w_rgb = 3'b010;
            else if (w_ball_on) w_rgb = 3'b100;
        end
    end

    // Sync and colour share one register stage so they stay aligned at the pins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hsync <= 1'b1;
            r_vsync <= 1'b1;
            r_rgb   <= 3'b000;
        end else if (w_tick) begin
            r_hsync <= w_hsync;
            r_vsync <= w_vsync;
            r_rgb   <= w_rgb;
        end
    end

    assign bus.hsync = r_hsync;
    assign bus.vsync = r_vsync;
    assign bus.rgb   = r_rgb;

    always_comb begin
        w_bar_next = r_bar_top;
        if (bus.btn != 2'b11) begin
            if (bus.btn[1] && (r_bar_top > BAR_UP_MIN))
                w_bar_next = r_bar_top - BAR_STEP;
            else if (bus.btn[0] && ((r_bar_top + BAR_SPAN) < BAR_DN_LIM))
                w_bar_next = r_bar_top + BAR_STEP;
        end
    end

    assign w_vel     = CW'(bus.sw) + CW'(1);
    assign w_hit_bar = ((r_ball_x + BALL_SPAN) >= BAR_L) && ((r_ball_x + BALL_SPAN) <= BAR_R) &&
                       ((r_ball_y + BALL_SPAN) >= r_bar_top) && (r_ball_y <= (r_bar_top + BAR_SPAN));
    assign w_miss    = (r_ball_x + BALL_SPAN) >= MISS_X;

    // Direction checks run in order against the current position, later ones win.
    always_comb begin
        w_dx_next = r_dx;
        w_dy_next = r_dy;
        if (r_ball_y <= BALL_TOP_LIM)               w_dy_next = 1'b1;
        if ((r_ball_y + BALL_SPAN) >= BALL_BOT_LIM) w_dy_next = 1'b0;
        if (r_ball_x <= WALL_R)                     w_dx_next = 1'b1;
        if (w_hit_bar)                              w_dx_next = 1'b0;
        w_x_next = w_dx_next ? r_ball_x + w_vel : r_ball_x - w_vel;
        w_y_next = w_dy_next ? r_ball_y + w_vel : r_ball_y - w_vel;
        if (w_miss) begin
            w_dx_next = 1'b1;
            w_dy_next = 1'b1;
            w_x_next  = BALL_X_RST;
            w_y_next  = BALL_Y_RST;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bar_top <= BAR_TOP_RST;
            r_ball_x  <= BALL_X_RST;
            r_ball_y  <= BALL_Y_RST;
            r_dx      <= 1'b1;
            r_dy      <= 1'b1;
        end else if (w_frame_tick) begin
            r_bar_top <= w_bar_next;
            if (bus.str) begin
                r_ball_x <= w_x_next;
                r_ball_y <= w_y_next;
                r_dx     <= w_dx_next;
                r_dy     <= w_dy_next;
            end
        end
    end

endmodule

// File: tb/tb_game_graph.sv
// tb_game_graph: directed checks of sync timing, paddle, ball motion/bounce/miss and pixel colours.
// Frame updates are accelerated by forcing the internal frame strobe for a chosen number of clocks.
module tb_game_graph;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    game_graph_if bus();

    game_graph dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #10 clk = ~clk;

`ifdef ROUND_BALL_EN
    localparam logic [2:0] CORNER_RGB = 3'b000;
`else
    localparam logic [2:0] CORNER_RGB = 3'b100;
`endif

    int         pix_h [13] = '{184, 33, 601, 100, 188, 700, 35, 36, 603, 604, 191, 192, 300};
    int         pix_v [13] = '{4, 5, 5, 8, 8, 8, 9, 9, 10, 10, 11, 11, 11};
    logic [2:0] pix_e [13] = '{CORNER_RGB, 3'b001, 3'b010, 3'b000, 3'b100, 3'b000,
                               3'b001, 3'b000, 3'b010, 3'b000, CORNER_RGB, 3'b000, 3'b000};

    task apply_reset();
        @(negedge clk);
        reset = 1'b1;
        #20;
        reset = 1'b0;
    endtask

    // Each forced clock is one game-state update.
    task frame_ticks(input int n);
        @(negedge clk);
        force dut.w_frame_tick = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        release dut.w_frame_tick;
        @(negedge clk);
    endtask

    task wait_pixel(input int h, input int v, output bit found);
        found = 1'b0;
        for (int i = 0; i < 40000; i++) begin
            @(negedge clk);
            if (dut.r_tick && dut.r_h == 10'(h) && dut.r_v == 10'(v)) begin
                found = 1'b1;
                break;
            end
        end
        if (found) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task test_reset();
        int n;
        @(negedge clk);
        reset = 1'b1;
        #5;
        n_tests++; if (bus.hsync !== 1'b1) begin n_fail++; $display("FAIL reset_hsync: got %b want 1", bus.hsync); end
        n_tests++; if (bus.vsync !== 1'b1) begin n_fail++; $display("FAIL reset_vsync: got %b want 1", bus.vsync); end
        n_tests++; if (bus.rgb !== 3'b000) begin n_fail++; $display("FAIL reset_rgb: got %b want 000", bus.rgb); end
        n_tests++; if ({dut.r_h, dut.r_v} !== 20'd0) begin n_fail++; $display("FAIL reset_counters: got h=%0d v=%0d want 0 0", dut.r_h, dut.r_v); end
        n_tests++; if (dut.r_bar_top !== 10'd204) begin n_fail++; $display("FAIL reset_bar: got %0d want 204", dut.r_bar_top); end
        n_tests++; if ({dut.r_ball_x, dut.r_ball_y, dut.r_dx, dut.r_dy} !== {10'd300, 10'd240, 2'b11})
            begin n_fail++; $display("FAIL reset_ball: got (%0d,%0d) d=%b%b want (300,240) d=11", dut.r_ball_x, dut.r_ball_y, dut.r_dx, dut.r_dy); end
        #15;
        reset = 1'b0;
        n = 0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.hsync === 1'b0) break;
        end
        n_tests++; if (n != 1314) begin n_fail++; $display("FAIL first_hsync_fall: got %0d clk want 1314", n); end
    endtask

    task test_hsync();
        int  low_n;
        int  high_n;
        bit  vs_ok;
        bit  blank_ok;
        low_n = 0; high_n = 0; vs_ok = 1'b1; blank_ok = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            low_n++;
            if (bus.vsync !== 1'b1) vs_ok = 1'b0;
            if (bus.hsync === 1'b1) break;
            if (bus.rgb !== 3'b000) blank_ok = 1'b0;
        end
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            #1;
            high_n++;
            if (bus.vsync !== 1'b1) vs_ok = 1'b0;
            if (bus.hsync === 1'b0) break;
        end
        n_tests++; if (low_n != 192) begin n_fail++; $display("FAIL hsync_low_width: got %0d clk want 192", low_n); end
        n_tests++; if (low_n + high_n != 1600) begin n_fail++; $display("FAIL hsync_period: got %0d clk want 1600", low_n + high_n); end
        n_tests++; if (vs_ok !== 1'b1) begin n_fail++; $display("FAIL vsync_idle: got low in first lines want high"); end
        n_tests++; if (blank_ok !== 1'b1) begin n_fail++; $display("FAIL blank_rgb: got nonzero rgb in hsync want 000"); end
    endtask

    task test_paddle();
        apply_reset();
        bus.str = 1'b0; bus.sw = 2'b00;
        bus.btn = 2'b10; frame_ticks(3);
        n_tests++; if (dut.r_bar_top !== 10'd192) begin n_fail++; $display("FAIL paddle_up3: got %0d want 192", dut.r_bar_top); end
        bus.btn = 2'b01; frame_ticks(10);
        n_tests++; if (dut.r_bar_top !== 10'd232) begin n_fail++; $display("FAIL paddle_down10: got %0d want 232", dut.r_bar_top); end
        frame_ticks(200);
        n_tests++; if (dut.r_bar_top !== 10'd408) begin n_fail++; $display("FAIL paddle_bottom_sat: got %0d want 408", dut.r_bar_top); end
        bus.btn = 2'b11; frame_ticks(5);
        n_tests++; if (dut.r_bar_top !== 10'd408) begin n_fail++; $display("FAIL paddle_both: got %0d want 408", dut.r_bar_top); end
        bus.btn = 2'b10; frame_ticks(110);
        n_tests++; if (dut.r_bar_top !== 10'd0) begin n_fail++; $display("FAIL paddle_top_sat: got %0d want 0", dut.r_bar_top); end
        n_tests++; if ({dut.r_ball_x, dut.r_ball_y} !== {10'd300, 10'd240})
            begin n_fail++; $display("FAIL paddle_ball_frozen: got (%0d,%0d) want (300,240)", dut.r_ball_x, dut.r_ball_y); end
        bus.btn = 2'b00;
    endtask

    task test_ball_motion();
        apply_reset();
        bus.btn = 2'b00; bus.str = 1'b1; bus.sw = 2'b01;
        frame_ticks(1);
        n_tests++; if ({dut.r_ball_x, dut.r_ball_y} !== {10'd302, 10'd242})
            begin n_fail++; $display("FAIL ball_step_v2: got (%0d,%0d) want (302,242)", dut.r_ball_x, dut.r_ball_y); end
        bus.str = 1'b0; frame_ticks(5);
        n_tests++; if ({dut.r_ball_x, dut.r_ball_y, dut.r_dx, dut.r_dy} !== {10'd302, 10'd242, 2'b11})
            begin n_fail++; $display("FAIL ball_hold: got (%0d,%0d) d=%b%b want (302,242) d=11", dut.r_ball_x, dut.r_ball_y, dut.r_dx, dut.r_dy); end
        bus.str = 1'b1; bus.sw = 2'b00; frame_ticks(1);
        n_tests++; if ({dut.r_ball_x, dut.r_ball_y} !== {10'd303, 10'd243})
            begin n_fail++; $display("FAIL ball_step_v1: got (%0d,%0d) want (303,243)", dut.r_ball_x, dut.r_ball_y); end
    endtask

    task test_bounce_miss();
        apply_reset();
        bus.btn = 2'b00; bus.str = 1'b1; bus.sw = 2'b11;
        frame_ticks(58);
        n_tests++; if ({dut.r_ball_x, dut.r_ball_y, dut.r_dy} !== {10'd532, 10'd472, 1'b1})
            begin n_fail++; $display("FAIL pre_bottom: got (%0d,%0d) dy=%b want (532,472) dy=1", dut.r_ball_x, dut.r_ball_y, dut.r_dy); end
        frame_ticks(1);
        n_tests++; if ({dut.r_ball_x, dut.r_ball_y, dut.r_dy} !== {10'd536, 10'd468, 1'b0})
            begin n_fail++; $display("FAIL bottom_bounce: got (%0d,%0d) dy=%b want (536,468) dy=0", dut.r_ball_x, dut.r_ball_y, dut.r_dy); end
        frame_ticks(24);
        n_tests++; if ({dut.r_ball_x, dut.r_ball_y} !== {10'd632, 10'd372})
            begin n_fail++; $display("FAIL pre_miss: got (%0d,%0d) want (632,372)", dut.r_ball_x, dut.r_ball_y); end
        frame_ticks(1);
        n_tests++; if ({dut.r_ball_x, dut.r_ball_y, dut.r_dx, dut.r_dy} !== {10'd300, 10'd240, 2'b11})
            begin n_fail++; $display("FAIL miss_respawn: got (%0d,%0d) d=%b%b want (300,240) d=11", dut.r_ball_x, dut.r_ball_y, dut.r_dx, dut.r_dy); end
    endtask

    task test_paddle_top_bounce();
        apply_reset();
        bus.btn = 2'b01; bus.str = 1'b1; bus.sw = 2'b11;
        frame_ticks(75);
        n_tests++; if ({dut.r_ball_x, dut.r_ball_y, dut.r_dx, dut.r_bar_top} !== {10'd592, 10'd404, 1'b0, 10'd408})
            begin n_fail++; $display("FAIL paddle_hit: got (%0d,%0d) dx=%b bar=%0d want (592,404) dx=0 bar=408", dut.r_ball_x, dut.r_ball_y, dut.r_dx, dut.r_bar_top); end
        frame_ticks(101);
        n_tests++; if ({dut.r_ball_x, dut.r_ball_y, dut.r_dy} !== {10'd188, 10'd0, 1'b0})
            begin n_fail++; $display("FAIL pre_top: got (%0d,%0d) dy=%b want (188,0) dy=0", dut.r_ball_x, dut.r_ball_y, dut.r_dy); end
        frame_ticks(1);
        n_tests++; if ({dut.r_ball_x, dut.r_ball_y, dut.r_dx, dut.r_dy} !== {10'd184, 10'd4, 2'b01})
            begin n_fail++; $display("FAIL top_bounce: got (%0d,%0d) d=%b%b want (184,4) d=01", dut.r_ball_x, dut.r_ball_y, dut.r_dx, dut.r_dy); end
    endtask

    // Continues from the top-bounce state; pixels are visited in raster order within the first lines.
    task test_render();
        bit found;
        bus.str = 1'b0; bus.btn = 2'b10;
        frame_ticks(102);
        bus.btn = 2'b00;
        n_tests++; if ({dut.r_bar_top, dut.r_ball_x, dut.r_ball_y} !== {10'd0, 10'd184, 10'd4})
            begin n_fail++; $display("FAIL render_setup: got bar=%0d ball=(%0d,%0d) want bar=0 ball=(184,4)", dut.r_bar_top, dut.r_ball_x, dut.r_ball_y); end
        for (int k = 0; k < 13; k++) begin
            wait_pixel(pix_h[k], pix_v[k], found);
            n_tests++;
            if (!found || bus.rgb !== pix_e[k]) begin
                n_fail++;
                $display("FAIL pixel_%0d_%0d: got %b (reached=%0d) want %b", pix_h[k], pix_v[k], bus.rgb, found, pix_e[k]);
            end
        end
    endtask

    initial begin
        clk = 1'b0; reset = 1'b0;
        bus.btn = 2'b00; bus.sw = 2'b00; bus.str = 1'b0;
        n_tests = 0; n_fail = 0;
        test_reset();
        test_hsync();
        test_paddle();
        test_ball_motion();
        test_bounce_miss();
        test_paddle_top_bounce();
        test_render();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
